// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: data-memory req/ack access,
// branch resolution and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        wb_ctlout,
    input  logic              branch,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [31:0]       EX_MEM_NPC,
    input  logic              zero,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       rdata2out,
    input  logic [4:0]        five_bit_muxout,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              pcsrc,
    output logic [31:0]       branch_target,
    output logic              stall,
    output logic              mem_err,
    output logic              mem_wb_valid,
    output logic [1:0]        mem_wb_ctl,
    output logic [31:0]       mem_wb_rdata,
    output logic [31:0]       mem_wb_alu,
    output logic [4:0]        mem_wb_rd
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               wb_valid_q, wb_valid_d;
    logic [1:0]         wb_ctl_q, wb_ctl_d;
    logic [31:0]        wb_rdata_q, wb_rdata_d;
    logic [31:0]        wb_alu_q, wb_alu_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic               stall_c;

    logic mem_op, illegal_op, legal_op, expire;

    assign mem_op     = memread | memwrite;
    assign illegal_op = in_valid & mem_op & ((memread & memwrite) | (alu_result[1:0] != 2'b00));
    assign legal_op   = in_valid & mem_op & ~illegal_op;
    assign expire     = (cnt_q == CNT_LAST);

    // Next-state, request and MEM/WB load decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        wb_valid_d = wb_valid_q;
        wb_ctl_d   = wb_ctl_q;
        wb_rdata_d = wb_rdata_q;
        wb_alu_d   = wb_alu_q;
        wb_rd_d    = wb_rd_q;
        stall_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (illegal_op) begin
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_ctl_d   = 2'b00;
                    wb_rdata_d = 32'h0;
                    wb_alu_d   = alu_result;
                    wb_rd_d    = five_bit_muxout;
                end else if (legal_op) begin
                    stall_c    = 1'b1;
                    state_d    = S_WAIT;
                    req_d      = 1'b1;
                    we_d       = memwrite;
                    addr_d     = ADDR_W'(alu_result);
                    wdata_d    = rdata2out;
                    cnt_d      = '0;
                    wb_valid_d = 1'b0;
                end else begin
                    wb_valid_d = in_valid;
                    wb_ctl_d   = in_valid ? wb_ctlout : 2'b00;
                    wb_rdata_d = 32'h0;
                    wb_alu_d   = alu_result;
                    wb_rd_d    = five_bit_muxout;
                end
            end
            S_WAIT: begin
                // An ack in the expiry cycle takes priority over the abort
                if (dmem_ack) begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_ctl_d   = wb_ctlout;
                    wb_rdata_d = we_q ? 32'h0 : dmem_rdata;
                    wb_alu_d   = alu_result;
                    wb_rd_d    = five_bit_muxout;
                end else if (expire) begin
                    state_d    = S_IDLE;
                    req_d      = 1'b0;
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_ctl_d   = 2'b00;
                    wb_rdata_d = 32'h0;
                    wb_alu_d   = alu_result;
                    wb_rd_d    = five_bit_muxout;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_ctl_q   <= 2'b00;
            wb_rdata_q <= 32'h0;
            wb_alu_q   <= 32'h0;
            wb_rd_q    <= 5'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            wb_valid_q <= wb_valid_d;
            wb_ctl_q   <= wb_ctl_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    // Stall is masked during reset so upstream is released immediately
    assign stall         = stall_c & rst_n;
    assign pcsrc         = in_valid & branch & zero;
    assign branch_target = EX_MEM_NPC;
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_err       = err_q;
    assign mem_wb_valid  = wb_valid_q;
    assign mem_wb_ctl    = wb_ctl_q;
    assign mem_wb_rdata  = wb_rdata_q;
    assign mem_wb_alu    = wb_alu_q;
    assign mem_wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with ACK_TIMEOUT=4: ALU pass-through, load,
// store, ack-at-expiry, misaligned, timeout, branch and mid-access reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero;
    logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        stall, mem_err, mem_wb_valid;
    logic [1:0]  mem_wb_ctl;
    logic [31:0] mem_wb_rdata, mem_wb_alu;
    logic [4:0]  mem_wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.ACK_TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .wb_ctlout(wb_ctlout),
        .branch(branch), .memread(memread), .memwrite(memwrite),
        .EX_MEM_NPC(EX_MEM_NPC), .zero(zero), .alu_result(alu_result),
        .rdata2out(rdata2out), .five_bit_muxout(five_bit_muxout),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
        .mem_err(mem_err), .mem_wb_valid(mem_wb_valid), .mem_wb_ctl(mem_wb_ctl),
        .mem_wb_rdata(mem_wb_rdata), .mem_wb_alu(mem_wb_alu), .mem_wb_rd(mem_wb_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; wb_ctlout = 2'b00; branch = 0; memread = 0; memwrite = 0;
        zero = 0; EX_MEM_NPC = 0; alu_result = 0; rdata2out = 0;
        five_bit_muxout = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic set_op(input logic rd_en, input logic wr_en, input logic [1:0] ctl,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd);
        in_valid = 1; memread = rd_en; memwrite = wr_en; wb_ctlout = ctl;
        alu_result = addr; rdata2out = wdata; five_bit_muxout = rd;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #1;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_wb_valid", 32'(mem_wb_valid), 0);
        chk("rst_wb_alu", mem_wb_alu, 0);
        tick();
        rst_n = 1;
        tick();

        // ALU op
        set_op(0, 0, 2'b10, 32'h1234, 0, 5'd5);
        #1;
        chk("alu_stall_c", 32'(stall), 0);
        tick();
        chk("alu_valid", 32'(mem_wb_valid), 1);
        chk("alu_ctl", 32'(mem_wb_ctl), 2'b10);
        chk("alu_alu", mem_wb_alu, 32'h1234);
        chk("alu_rd", 32'(mem_wb_rd), 5);
        chk("alu_rdata", mem_wb_rdata, 0);
        chk("alu_req", 32'(dmem_req), 0);

        // Branch resolution
        branch = 1; zero = 1; EX_MEM_NPC = 32'h100;
        #1;
        chk("br_pcsrc1", 32'(pcsrc), 1);
        chk("br_target", branch_target, 32'h100);
        zero = 0;
        #1;
        chk("br_pcsrc0", 32'(pcsrc), 0);
        idle_inputs();
        tick();

        // Load, ack on third WAIT cycle
        set_op(1, 0, 2'b11, 32'h40, 0, 5'd7);
        #1;
        chk("ld_stall_issue", 32'(stall), 1);
        chk("ld_req_issue", 32'(dmem_req), 0);
        tick();
        chk("ld_req_w1", 32'(dmem_req), 1);
        chk("ld_addr_w1", dmem_addr, 32'h40);
        chk("ld_we_w1", 32'(dmem_we), 0);
        chk("ld_stall_w1", 32'(stall), 1);
        chk("ld_wbvalid_w1", 32'(mem_wb_valid), 0);
        tick();
        chk("ld_req_w2", 32'(dmem_req), 1);
        chk("ld_stall_w2", 32'(stall), 1);
        tick();
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_req_w3", 32'(dmem_req), 1);
        chk("ld_stall_ack", 32'(stall), 0);
        tick();
        dmem_ack = 0; dmem_rdata = 0;
        chk("ld_req_done", 32'(dmem_req), 0);
        chk("ld_wb_valid", 32'(mem_wb_valid), 1);
        chk("ld_wb_ctl", 32'(mem_wb_ctl), 2'b11);
        chk("ld_wb_rdata", mem_wb_rdata, 32'hDEADBEEF);
        chk("ld_wb_alu", mem_wb_alu, 32'h40);
        chk("ld_wb_rd", 32'(mem_wb_rd), 7);
        idle_inputs();
        tick();

        // Store, ack on first WAIT cycle
        set_op(0, 1, 2'b00, 32'h80, 32'hCAFEF00D, 5'd0);
        #1;
        chk("st_stall_issue", 32'(stall), 1);
        tick();
        chk("st_req", 32'(dmem_req), 1);
        chk("st_we", 32'(dmem_we), 1);
        chk("st_addr", dmem_addr, 32'h80);
        chk("st_wdata", dmem_wdata, 32'hCAFEF00D);
        dmem_ack = 1; dmem_rdata = 32'h55555555;
        #1;
        chk("st_stall_ack", 32'(stall), 0);
        tick();
        dmem_ack = 0;
        chk("st_req_done", 32'(dmem_req), 0);
        chk("st_wb_valid", 32'(mem_wb_valid), 1);
        chk("st_wb_ctl", 32'(mem_wb_ctl), 0);
        chk("st_wb_rdata", mem_wb_rdata, 0);
        chk("st_err", 32'(mem_err), 0);
        idle_inputs();
        tick();

        // Load whose ack lands in the expiry cycle: ack wins
        set_op(1, 0, 2'b11, 32'h48, 0, 5'd9);
        tick(); tick(); tick(); tick();
        chk("ax_req_last", 32'(dmem_req), 1);
        dmem_ack = 1; dmem_rdata = 32'h0BADF00D;
        #1;
        chk("ax_stall", 32'(stall), 0);
        tick();
        dmem_ack = 0;
        chk("ax_err", 32'(mem_err), 0);
        chk("ax_wb_ctl", 32'(mem_wb_ctl), 2'b11);
        chk("ax_wb_rdata", mem_wb_rdata, 32'h0BADF00D);
        idle_inputs();
        tick();

        // Misaligned load
        set_op(1, 0, 2'b11, 32'h42, 0, 5'd4);
        #1;
        chk("mis_stall", 32'(stall), 0);
        tick();
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_err", 32'(mem_err), 1);
        chk("mis_wb_valid", 32'(mem_wb_valid), 1);
        chk("mis_wb_ctl", 32'(mem_wb_ctl), 0);
        idle_inputs();

        // Reset clears sticky error
        rst_n = 0;
        #1;
        chk("rst2_err", 32'(mem_err), 0);
        tick();
        rst_n = 1;
        tick();

        // Load timeout
        set_op(1, 0, 2'b11, 32'h44, 0, 5'd3);
        tick();
        chk("to_req1", 32'(dmem_req), 1);
        chk("to_stall1", 32'(stall), 1);
        tick();
        chk("to_req2", 32'(dmem_req), 1);
        tick();
        chk("to_req3", 32'(dmem_req), 1);
        chk("to_stall3", 32'(stall), 1);
        tick();
        chk("to_req4", 32'(dmem_req), 1);
        chk("to_stall4", 32'(stall), 0);
        chk("to_err_pre", 32'(mem_err), 0);
        tick();
        chk("to_req_drop", 32'(dmem_req), 0);
        chk("to_err", 32'(mem_err), 1);
        chk("to_wb_valid", 32'(mem_wb_valid), 1);
        chk("to_wb_ctl", 32'(mem_wb_ctl), 0);
        idle_inputs();
        tick();

        // Reset mid-WAIT, later ack ignored
        set_op(1, 0, 2'b11, 32'h50, 0, 5'd2);
        tick();
        chk("rw_req", 32'(dmem_req), 1);
        rst_n = 0;
        #1;
        chk("rw_req_rst", 32'(dmem_req), 0);
        chk("rw_stall_rst", 32'(stall), 0);
        chk("rw_wb_valid", 32'(mem_wb_valid), 0);
        chk("rw_wb_ctl", 32'(mem_wb_ctl), 0);
        chk("rw_wb_alu", mem_wb_alu, 0);
        chk("rw_wb_rd", 32'(mem_wb_rd), 0);
        chk("rw_err", 32'(mem_err), 0);
        idle_inputs();
        tick();
        rst_n = 1;
        dmem_ack = 1; dmem_rdata = 32'h12345678;
        tick();
        dmem_ack = 0;
        chk("rw_ack_req", 32'(dmem_req), 0);
        chk("rw_ack_valid", 32'(mem_wb_valid), 0);
        chk("rw_ack_rdata", mem_wb_rdata, 0);
        chk("rw_ack_err", 32'(mem_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
